// File: rtl/conv_window_buffer.sv
// Purpose: streaming KxK sliding-window generator for 2D convolution over an N_IMAGE x N_IMAGE raster image.
// Latency: 1 cycle, registered; the window completed by the pixel accepted at edge t is valid after edge t.
// Backpressure: none; every accepted pixel is absorbed and every o_window_valid pulse must be consumed.
//
// Ports:
//   clk            - single clock, rising edge
//   clear          - synchronous active-high reset; wins over i_data_valid
//   i_data         - input pixel, raster order, top-left first
//   i_data_valid   - i_data is accepted this cycle
//   o_window       - o_window[r][c] = pixel(y-r, x-c), (y,x) = newest accepted pixel
//   o_window_valid - one-cycle pulse: o_window is a complete in-image neighbourhood
//   o_window_end   - with o_window_valid: last window of the frame
module conv_window_buffer #(
    parameter int N_IMAGE  = 8,
    parameter int K_KERNEL = 3,
    parameter int BWD      = 1
) (
    input  logic                                         clk,
    input  logic                                         clear,
    input  logic [BWD-1:0]                               i_data,
    input  logic                                         i_data_valid,
    output logic [K_KERNEL-1:0][K_KERNEL-1:0][BWD-1:0]   o_window,
    output logic                                         o_window_valid,
    output logic                                         o_window_end
);

    localparam int            CW   = (N_IMAGE > 1) ? $clog2(N_IMAGE) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_IMAGE - 1);
    localparam logic [CW-1:0] KM1  = CW'(K_KERNEL - 1);

    // Position of the pixel currently offered on i_data.
    logic [CW-1:0] row;
    logic [CW-1:0] col;

    // line_buf[k][0] is the most recently shifted-in pixel, line_buf[k][N-1]
    // the oldest. Line buffer k feeds line buffer k+1, so line_buf[k][N-1]
    // is the pixel exactly (k+1) rows above the incoming one, same column.
    logic [K_KERNEL-2:0][N_IMAGE-1:0][BWD-1:0] line_buf;

    // Column of K pixels entering the window at c=0: newest pixel at r=0,
    // then the vertically aligned pixels of the rows above.
    logic [K_KERNEL-1:0][BWD-1:0] new_col;

    logic win_done;
    logic frame_end;

    always_comb begin
        new_col    = '0;
        new_col[0] = i_data;
        for (int r = 1; r < K_KERNEL; r++) begin
            new_col[r] = line_buf[r-1][N_IMAGE-1];
        end
    end

    // A window is complete only when the incoming pixel is far enough from
    // the top and left edges; this also suppresses windows that would wrap
    // onto the previous row's tail still sitting in the register array.
    assign win_done  = (row >= KM1) && (col >= KM1);
    assign frame_end = (row == LAST) && (col == LAST);

    always_ff @(posedge clk) begin
        if (clear) begin
            row            <= '0;
            col            <= '0;
            line_buf       <= '0;
            o_window       <= '0;
            o_window_valid <= 1'b0;
            o_window_end   <= 1'b0;
        end else begin
            o_window_valid <= 1'b0;
            o_window_end   <= 1'b0;
            if (i_data_valid) begin
                line_buf[0] <= {line_buf[0][N_IMAGE-2:0], i_data};
                for (int k = 1; k < K_KERNEL - 1; k++) begin
                    line_buf[k] <= {line_buf[k][N_IMAGE-2:0], line_buf[k-1][N_IMAGE-1]};
                end
                // Shift each window row one column to the left (towards
                // higher c) and insert the new column at c=0.
                for (int r = 0; r < K_KERNEL; r++) begin
                    o_window[r] <= {o_window[r][K_KERNEL-2:0], new_col[r]};
                end
                o_window_valid <= win_done;
                o_window_end   <= win_done && frame_end;
                if (col == LAST) begin
                    col <= '0;
                    row <= (row == LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_window_buffer.sv
module tb_conv_window_buffer;

    typedef struct packed {
        logic [2:0][2:0][7:0] win;
        logic                 last;
        logic [31:0]          idx;
        logic [31:0]          due;
    } e8_t;

    typedef struct packed {
        logic [2:0][2:0][0:0] win;
        logic                 last;
        logic [31:0]          due;
    } e1_t;

    logic                  clk = 1'b0;
    logic                  clear;
    logic [7:0]            d8_dat;
    logic                  d8_vld;
    logic [0:0]            d1_dat;
    logic                  d1_vld;
    logic [2:0][2:0][7:0]  w8;
    logic                  w8_vld;
    logic                  w8_end;
    logic [2:0][2:0][0:0]  w1;
    logic                  w1_vld;
    logic                  w1_end;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state
    int  img [8][8];
    int  mrow, mcol, midx, mode;
    e8_t q8 [$];
    e1_t q1 [$];

    // Observation logs
    logic [2:0][2:0][7:0] log8 [$];
    int                   idx8 [$];
    logic                 end8 [$];
    int pulses8 = 0, ends8 = 0, pulses1 = 0, ends1 = 0;

    conv_window_buffer #(.N_IMAGE(8), .K_KERNEL(3), .BWD(8)) dut8 (
        .clk            (clk),
        .clear          (clear),
        .i_data         (d8_dat),
        .i_data_valid   (d8_vld),
        .o_window       (w8),
        .o_window_valid (w8_vld),
        .o_window_end   (w8_end)
    );

    conv_window_buffer #(.N_IMAGE(8), .K_KERNEL(3), .BWD(1)) dut1 (
        .clk            (clk),
        .clear          (clear),
        .i_data         (d1_dat),
        .i_data_valid   (d1_vld),
        .o_window       (w1),
        .o_window_valid (w1_vld),
        .o_window_end   (w1_end)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Samples both DUTs on the falling edge. An expected item is due on the
    // edge after the one at which its pixel was driven.
    task automatic monitor();
        e8_t                  e;
        e1_t                  f;
        logic                 ev;
        logic                 skip8 = 1'b1;
        logic                 skip1 = 1'b1;
        logic [2:0][2:0][7:0] last_w8 = '0;
        logic [2:0][2:0][0:0] last_w1 = '0;
        forever begin
            @(negedge clk);
            if (!skip8) chk("hold8", 128'(w8), 128'(last_w8));
            if (!skip1) chk("hold1", 128'(w1), 128'(last_w1));

            ev = (q8.size() > 0) && (q8[0].due == 32'(cyc));
            chk("valid8", 128'(w8_vld), 128'(ev));
            if (ev) begin
                e = q8.pop_front();
                chk("win8", 128'(w8), 128'(e.win));
                chk("end8", 128'(w8_end), 128'(e.last));
                log8.push_back(w8);
                idx8.push_back(int'(e.idx));
                end8.push_back(w8_end);
                pulses8++;
                if (w8_end) ends8++;
            end else begin
                chk("end8_idle", 128'(w8_end), 128'(0));
            end

            ev = (q1.size() > 0) && (q1[0].due == 32'(cyc));
            chk("valid1", 128'(w1_vld), 128'(ev));
            if (ev) begin
                f = q1.pop_front();
                chk("win1", 128'(w1), 128'(f.win));
                chk("end1", 128'(w1_end), 128'(f.last));
                pulses1++;
                if (w1_end) ends1++;
            end else begin
                chk("end1_idle", 128'(w1_end), 128'(0));
            end

            // Inputs visible now are the ones sampled at the next rising edge.
            skip8   = d8_vld | clear;
            skip1   = d1_vld | clear;
            last_w8 = w8;
            last_w1 = w1;
        end
    endtask

    // Drive one cycle; on an accepted pixel update the model and queue the
    // window it completes.
    task automatic step(input bit v);
        int  val;
        e8_t e;
        e1_t f;
        d8_vld = (mode == 0) ? v : 1'b0;
        d1_vld = (mode == 1) ? v : 1'b0;
        if (v) begin
            val = (mode == 1) ? ((mrow + mcol) & 1) : (8 * mrow + mcol);
            img[mrow][mcol] = val;
            d8_dat = 8'(val);
            d1_dat = 1'(val);
            if (mrow >= 2 && mcol >= 2) begin
                if (mode == 0) begin
                    for (int r = 0; r < 3; r++)
                        for (int c = 0; c < 3; c++)
                            e.win[r][c] = 8'(img[mrow-r][mcol-c]);
                    e.last = (mrow == 7) && (mcol == 7);
                    e.idx  = 32'(midx);
                    e.due  = 32'(cyc + 1);
                    q8.push_back(e);
                end else begin
                    for (int r = 0; r < 3; r++)
                        for (int c = 0; c < 3; c++)
                            f.win[r][c] = 1'(img[mrow-r][mcol-c]);
                    f.last = (mrow == 7) && (mcol == 7);
                    f.due  = 32'(cyc + 1);
                    q1.push_back(f);
                end
            end
            midx = (midx == 63) ? 0 : midx + 1;
            if (mcol == 7) begin
                mcol = 0;
                mrow = (mrow == 7) ? 0 : mrow + 1;
            end else begin
                mcol++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Clear asserted together with a valid pixel: the pixel must be dropped.
    task automatic do_clear();
        clear  = 1'b1;
        d8_vld = 1'b1;
        d8_dat = 8'hA5;
        d1_vld = 1'b1;
        d1_dat = 1'b1;
        @(posedge clk);
        #1;
        clear  = 1'b0;
        d8_vld = 1'b0;
        d1_vld = 1'b0;
        chk("clr_win8", 128'(w8), 128'(0));
        chk("clr_vld8", 128'(w8_vld), 128'(0));
        chk("clr_end8", 128'(w8_end), 128'(0));
        chk("clr_win1", 128'(w1), 128'(0));
        chk("clr_q8", 128'(q8.size()), 128'(0));
        mrow = 0;
        mcol = 0;
        midx = 0;
    endtask

    task automatic drain();
        repeat (3) step(1'b0);
        chk("drain_q8", 128'(q8.size()), 128'(0));
        chk("drain_q1", 128'(q1.size()), 128'(0));
    endtask

    task automatic check_first(input string tag, input int b);
        logic [2:0][2:0][7:0] fw;
        if (log8.size() > b) begin
            fw = log8[b];
            chk({tag, "_idx"}, 128'(idx8[b]), 128'(18));
            chk({tag, "_00"}, 128'(fw[0][0]), 128'(18));
            chk({tag, "_02"}, 128'(fw[0][2]), 128'(16));
            chk({tag, "_20"}, 128'(fw[2][0]), 128'(2));
            chk({tag, "_22"}, 128'(fw[2][2]), 128'(0));
        end else begin
            chk({tag, "_present"}, 128'(log8.size()), 128'(b + 1));
        end
    endtask

    initial begin
        int b, eb, acc;
        logic [2:0][2:0][7:0] lw;
        mrow = 0; mcol = 0; midx = 0; mode = 0;
        clear = 1'b1;
        d8_vld = 1'b0; d8_dat = '0;
        d1_vld = 1'b0; d1_dat = '0;
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        #1;
        chk("rst_win8", 128'(w8), 128'(0));
        chk("rst_vld8", 128'(w8_vld), 128'(0));
        chk("rst_end8", 128'(w8_end), 128'(0));
        chk("rst_win1", 128'(w1), 128'(0));
        clear = 1'b0;
        step(1'b0);

        // Contiguous frame
        b = pulses8; eb = ends8;
        repeat (64) step(1'b1);
        drain();
        chk("f1_pulses", 128'(pulses8 - b), 128'(36));
        chk("f1_ends", 128'(ends8 - eb), 128'(1));
        check_first("f1_first", b);
        if (log8.size() >= b + 36) begin
            lw = log8[b+35];
            chk("f1_last_end", 128'(end8[b+35]), 128'(1));
            chk("f1_last_00", 128'(lw[0][0]), 128'(63));
            chk("f1_last_22", 128'(lw[2][2]), 128'(45));
        end

        // Random bubbles
        b = pulses8; acc = 0;
        while (acc < 64) begin
            if ($urandom_range(0, 1) == 1) begin
                step(1'b1);
                acc++;
            end else begin
                step(1'b0);
            end
        end
        drain();
        chk("bub_pulses", 128'(pulses8 - b), 128'(36));

        // Back-to-back frames
        b = pulses8; eb = ends8;
        repeat (128) step(1'b1);
        drain();
        chk("b2b_pulses", 128'(pulses8 - b), 128'(72));
        chk("b2b_ends", 128'(ends8 - eb), 128'(2));
        if (log8.size() >= b + 37)
            chk("b2b_first_eq", 128'(log8[b+36]), 128'(log8[b]));
        check_first("b2b_first", b);

        // Mid-frame clear
        repeat (30) step(1'b1);
        do_clear();
        b = pulses8; eb = ends8;
        repeat (64) step(1'b1);
        drain();
        chk("mc_pulses", 128'(pulses8 - b), 128'(36));
        chk("mc_ends", 128'(ends8 - eb), 128'(1));
        check_first("mc_first", b);

        // 1-bit checkerboard
        mode = 1;
        b = pulses1; eb = ends1;
        repeat (64) step(1'b1);
        drain();
        chk("cb_pulses", 128'(pulses1 - b), 128'(36));
        chk("cb_ends", 128'(ends1 - eb), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
